fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited in-order instruction fetch with redirect/discard; ifid_tdata = {inst, pc}.
// Define OFFNARISCV_FETCH_PERF_EN to add the perf_fetched delivery counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h8000_0000,
    parameter int          MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_tvalid,
    input  logic        imem_req_tready,
    output logic [31:0] imem_req_tdata,
    input  logic        imem_rsp_tvalid,
    output logic        imem_rsp_tready,
    input  logic [31:0] imem_rsp_tdata,
    output logic        ifid_tvalid,
    input  logic        ifid_tready,
    output logic [63:0] ifid_tdata,
    input  logic        redirect_vld,
    input  logic [31:0] redirect_pc
`ifdef OFFNARISCV_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched
`endif
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam logic [PW-1:0] LAST = PW'(MAX_INFLIGHT - 1);

    logic [31:0]   pc;
    logic [CW-1:0] inflight, inflight_nxt, discard_cnt, buf_cnt;
    logic [PW-1:0] pq_wr, pq_rd, ob_wr, ob_rd;
    logic [31:0]   pq_mem [MAX_INFLIGHT];
    logic [31:0]   ob_inst [MAX_INFLIGHT];
    logic [31:0]   ob_pc [MAX_INFLIGHT];
    logic          req_hs, rsp_hs, accept, pop, credit;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == LAST ? '0 : p + 1'b1;
    endfunction

    // Credits cover both outstanding requests and buffered words, so every response has a slot.
    assign credit          = ({1'b0, inflight} + {1'b0, buf_cnt}) < (CW + 1)'(MAX_INFLIGHT);
    assign imem_req_tvalid = rst && !redirect_vld && credit;
    assign imem_req_tdata  = pc;
    assign imem_rsp_tready = 1'b1;
    assign req_hs          = imem_req_tvalid && imem_req_tready;
    assign rsp_hs          = imem_rsp_tvalid;
    assign accept          = rsp_hs && discard_cnt == '0 && !redirect_vld;
    assign pop             = ifid_tvalid && ifid_tready && !redirect_vld;
    assign inflight_nxt    = inflight + CW'(req_hs) - CW'(rsp_hs);
    assign ifid_tvalid     = buf_cnt != '0;
    assign ifid_tdata      = {ob_inst[ob_rd], ob_pc[ob_rd]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            inflight    <= '0;
            discard_cnt <= '0;
            buf_cnt     <= '0;
            pq_wr       <= '0;
            pq_rd       <= '0;
            ob_wr       <= '0;
            ob_rd       <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (redirect_vld) begin
                pc          <= redirect_pc & ~32'h3;
                discard_cnt <= inflight_nxt;
                pq_rd       <= pq_wr;
                ob_wr       <= '0;
                ob_rd       <= '0;
                buf_cnt     <= '0;
            end else begin
                if (req_hs) begin
                    pc    <= pc + 32'd4;
                    pq_wr <= nxt(pq_wr);
                end
                if (rsp_hs && discard_cnt != '0)
                    discard_cnt <= discard_cnt - 1'b1;
                if (accept) begin
                    pq_rd <= nxt(pq_rd);
                    ob_wr <= nxt(ob_wr);
                end
                if (pop)
                    ob_rd <= nxt(ob_rd);
                buf_cnt <= buf_cnt + CW'(accept) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_hs)
            pq_mem[pq_wr] <= pc;
        if (accept) begin
            ob_inst[ob_wr] <= imem_rsp_tdata;
            ob_pc[ob_wr]   <= pq_mem[pq_rd];
        end
    end

`ifdef OFFNARISCV_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            perf_fetched <= '0;
        else if (pop)
            perf_fetched <= perf_fetched + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors for fetch_unit against an in-order, one-cycle-latency memory model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_tvalid, imem_req_tready = 1'b1;
    logic [31:0] imem_req_tdata;
    logic        imem_rsp_tvalid = 1'b0, imem_rsp_tready;
    logic [31:0] imem_rsp_tdata = 32'h0;
    logic        ifid_tvalid, ifid_tready = 1'b1;
    logic [63:0] ifid_tdata;
    logic        redirect_vld = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        rsp_en = 1'b1;
    int          n_vec = 0, n_err = 0, n_fetch = 0;
    logic [31:0] mq[$];
`ifdef OFFNARISCV_FETCH_PERF_EN
    logic [31:0] perf_fetched;
`endif

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req_tvalid(imem_req_tvalid), .imem_req_tready(imem_req_tready), .imem_req_tdata(imem_req_tdata),
        .imem_rsp_tvalid(imem_rsp_tvalid), .imem_rsp_tready(imem_rsp_tready), .imem_rsp_tdata(imem_rsp_tdata),
        .ifid_tvalid(ifid_tvalid), .ifid_tready(ifid_tready), .ifid_tdata(ifid_tdata),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc)
`ifdef OFFNARISCV_FETCH_PERF_EN
        , .perf_fetched(perf_fetched)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Memory returns responses in order, one cycle after the request at the earliest.
    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
            n_fetch = 0;
        end else begin
            if (imem_rsp_tvalid)
                void'(mq.pop_front());
            if (imem_req_tvalid && imem_req_tready)
                mq.push_back(imem_req_tdata);
            if (ifid_tvalid && ifid_tready && !redirect_vld)
                n_fetch++;
        end
        #1;
        imem_rsp_tvalid = rst && rsp_en && mq.size() != 0;
        imem_rsp_tdata  = imem_rsp_tvalid ? inst_of(mq[0]) : 32'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic rv, input logic [31:0] rpc,
                              input logic iv, input logic [31:0] ipc);
        chk({tag, ".req_valid"}, 32'(imem_req_tvalid), 32'(rv));
        if (rv)
            chk({tag, ".req_pc"}, imem_req_tdata, rpc);
        chk({tag, ".ifid_valid"}, 32'(ifid_tvalid), 32'(iv));
        if (iv) begin
            chk({tag, ".ifid_pc"}, ifid_tdata[31:0], ipc);
            chk({tag, ".ifid_inst"}, ifid_tdata[63:32], inst_of(ipc));
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;
    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000};
        tbl[3]  = '{1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0004};
        tbl[4]  = '{1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008};
        tbl[5]  = '{1'b1, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_000C};
        tbl[6]  = '{1'b0, 1'b1, 32'h8000_0018, 1'b1, 32'h8000_0010};
        tbl[7]  = '{1'b0, 1'b1, 32'h8000_001C, 1'b1, 32'h8000_0010};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0010};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0010};
        tbl[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0010};
        tbl[11] = '{1'b0, 1'b1, 32'h8000_0020, 1'b1, 32'h8000_0014};
        tbl[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0014};
        tbl[13] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0014};
        tbl[14] = '{1'b1, 1'b1, 32'h8000_0024, 1'b1, 32'h8000_0018};
        tbl[15] = '{1'b1, 1'b1, 32'h8000_0028, 1'b1, 32'h8000_001C};
        tbl[16] = '{1'b1, 1'b1, 32'h8000_002C, 1'b1, 32'h8000_0020};
        tbl[17] = '{1'b1, 1'b1, 32'h8000_0030, 1'b1, 32'h8000_0024};

        repeat (2) @(negedge clk);
        chk("reset.req_valid", 32'(imem_req_tvalid), 32'd0);
        chk("reset.ifid_valid", 32'(ifid_tvalid), 32'd0);
        chk("reset.pc", imem_req_tdata, 32'h8000_0000);
        @(negedge clk);
        rst = 1'b1;
        foreach (tbl[i]) begin
            ifid_tready = tbl[i].rdy;
            #1;
            expect_out($sformatf("vec%0d", i), tbl[i].rv, tbl[i].rpc, tbl[i].iv, tbl[i].ipc);
            @(negedge clk);
        end

        // Asynchronous reset with two words buffered.
        #2 rst = 1'b0;
        #1;
        chk("async_rst.req_valid", 32'(imem_req_tvalid), 32'd0);
        chk("async_rst.ifid_valid", 32'(ifid_tvalid), 32'd0);
        rsp_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 expect_out("rel0", 1'b1, 32'h8000_0000, 1'b0, 32'h0);
        @(negedge clk); #1 expect_out("rel1", 1'b1, 32'h8000_0004, 1'b0, 32'h0);
        @(negedge clk); #1 expect_out("rel2", 1'b1, 32'h8000_0008, 1'b0, 32'h0);

        // Redirect with three requests outstanding; their responses must be dropped.
        @(negedge clk);
        redirect_vld = 1'b1;
        redirect_pc  = 32'h0000_1002;
        #1 expect_out("redir", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        redirect_vld = 1'b0;
        rsp_en       = 1'b1;
        #1 expect_out("rd4", 1'b1, 32'h0000_1000, 1'b0, 32'h0);
        @(negedge clk); #1 expect_out("rd5", 1'b0, 32'h0,         1'b0, 32'h0);
        @(negedge clk); #1 expect_out("rd6", 1'b1, 32'h0000_1004, 1'b0, 32'h0);
        @(negedge clk); #1 expect_out("rd7", 1'b1, 32'h0000_1008, 1'b0, 32'h0);
        @(negedge clk); #1 expect_out("rd8", 1'b1, 32'h0000_100C, 1'b0, 32'h0);
        @(negedge clk); #1 expect_out("rd9", 1'b0, 32'h0,         1'b1, 32'h0000_1000);

        // Redirect near the top of the address space, with an ifid handshake and a response in that cycle.
        @(negedge clk);
        redirect_vld = 1'b1;
        redirect_pc  = 32'hFFFF_FFF9;
        #1 expect_out("wrap_redir", 1'b0, 32'h0, 1'b1, 32'h0000_1004);
        @(negedge clk);
        redirect_vld = 1'b0;
        #1 expect_out("wr1", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
        @(negedge clk); #1 expect_out("wr2", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        @(negedge clk); #1 expect_out("wr3", 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8);
        @(negedge clk); #1 expect_out("wr4", 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk); #1 expect_out("wr5", 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000);
`ifdef OFFNARISCV_FETCH_PERF_EN
        chk("perf.count", perf_fetched, 32'(n_fetch));
        @(negedge clk);
        redirect_vld = 1'b1;
        @(negedge clk);
        redirect_vld = 1'b0;
        #1 chk("perf.after_redirect", perf_fetched, 32'(n_fetch));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
